caravel_la_core: RTL and testbench
==================================

CARAVEL_LA_CORE -- requirements
Module: caravel_la_core

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 wb_clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-004 la_data_in  in  128  mgmt-to-block bus: [31:0] data word, [33:32] operand address, [34] write strobe, [35] start, [36] ack, [37] clear, [127:38] unused.
REQ-005 la_oenb  in  128  per-bit qualifier: la_data_in[i] is used only when la_oenb[i]=0, otherwise it reads as 0.
REQ-006 la_data_out  out  128  block-to-mgmt bus: [63:0] result, [66:64] state code, [67] busy, [68] result_valid, [127:69] tied 0.
REQ-007 io_out  out  38  [31:16] status word; all other bits 0.
REQ-008 io_oeb  out  38  0 on bits [31:16]; 1 on all other bits.

Function
REQ-009 Edge detection: strobe, start, ack and clear act on rising edges only (qualified bit=1 now, registered copy=0); edge registers reset to 0.
REQ-010 The block SHALL implement six states, each with a fixed 3-bit code and status word:
- IDLE: code 0, status 16'hAB40.
- LOAD: code 1, status 16'hAB41.
- BUSY: code 2, status 16'hAB42.
- RESULT: code 3, status 16'hAB51.
- DONE: code 4, status 16'hAB43.
- ERROR: code 5, status 16'hAB44.
REQ-011 Strobe edge in IDLE or LOAD: latch data word into A (address 0) or B (address 1); addresses 2 and 3 are ignored; set that operand's loaded flag; state becomes LOAD.
REQ-012 Start edge in LOAD with both loaded flags set: go to BUSY with counter=0 and accumulator=0.
REQ-013 Start edge in IDLE, or in LOAD with an operand missing: go to ERROR.
REQ-014 BUSY performs a bit-serial carry-less multiply, one cycle per bit of B, LSB first: if B[cnt]=1, acc ^= (zero-extended A << cnt).
REQ-015 BUSY lasts exactly 32 cycles; the cycle after cnt=31 enters RESULT, with result = 64-bit acc.
REQ-016 Strobe or start edge during BUSY: go to ERROR; the multiply is aborted.
REQ-017 result_valid=1 in RESULT and DONE; busy=1 only in BUSY; la_data_out[63:0] holds the result while result_valid=1, else 0.
REQ-018 Ack edge in RESULT compares la_data_in[31:0] with result[31:0]: equal -> DONE, unequal -> ERROR.
REQ-019 Ack edges outside RESULT are ignored.
REQ-020 Clear edge in any state except BUSY: return to IDLE, clear the loaded flags, A, B and acc.
REQ-021 Clear during BUSY is ignored.
REQ-022 Simultaneous edges in one cycle have priority clear > start > strobe > ack.
REQ-023 The operand A and B registers keep their values in DONE and ERROR until clear or reset.
REQ-024 All outputs are registered or decoded from registered state only; there is no combinational path from la_data_in to la_data_out or io_out.

Reset
REQ-025 While wb_rst_i=1, at the next clock edge the block SHALL enter IDLE with A, B, acc, counter, loaded flags and edge registers all 0.
REQ-026 After reset: io_out[31:16]=16'hAB40, la_data_out=0, io_oeb as in REQ-008.
REQ-027 Reset asserted in any state, including mid-BUSY, overrides every other event in that cycle.

Verification
REQ-028 Reset, then load A=0x00000003 and B=0x00000003, then start -> status AB41, AB42 for 32 cycles, then AB51 with result 0x0000000000000005; ack with 0x00000005 -> AB43.
REQ-029 Load A=B=0xFFFFFFFF, start -> result 0x5555555555555555; ack with 0x00000000 -> AB44, result_valid=0.
REQ-030 Load only A=0x12345678, then start -> AB44; clear -> AB40, la_data_out=0.
REQ-031 Strobe edge at BUSY cycle 10 -> AB44 on the next cycle; clear -> AB40.
REQ-032 Assert wb_rst_i at BUSY cycle 5 -> AB40, all la_data_out bits 0; a fresh load/start sequence then gives the correct result.
REQ-033 With la_oenb[35]=1, pulse la_data_in[35] in LOAD (both operands loaded) -> the state stays LOAD with status AB41.

Source files
------------

// File: rtl/caravel_la_core.sv
// Logic-analyzer driven carry-less multiplier: operands, control edges and results travel over the
// LA bus, and a fixed-code status word is presented on io_out[31:16].
module caravel_la_core (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [127:0] la_data_in,
  input  logic [127:0] la_oenb,
  output logic [127:0] la_data_out,
  output logic [37:0]  io_out,
  output logic [37:0]  io_oeb
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_BUSY   = 3'd2,
    S_RESULT = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [63:0] r_acc;
  logic [4:0]  r_cnt;
  logic        r_loaded_a;
  logic        r_loaded_b;
  logic        r_strobe_q;
  logic        r_start_q;
  logic        r_ack_q;
  logic        r_clear_q;

  logic [127:0] w_la;
  logic [31:0]  w_data;
  logic [1:0]   w_addr;
  logic         w_strobe_edge;
  logic         w_start_edge;
  logic         w_ack_edge;
  logic         w_clear_edge;
  logic         w_load_a;
  logic         w_load_b;
  logic         w_clear_all;
  logic         w_start_mul;
  logic         w_busy_step;
  logic [63:0]  w_term;
  logic         w_busy;
  logic         w_result_valid;
  logic [15:0]  w_status;

  assign w_la          = la_data_in & ~la_oenb;
  assign w_data        = w_la[31:0];
  assign w_addr        = w_la[33:32];
  assign w_strobe_edge = w_la[34] & ~r_strobe_q;
  assign w_start_edge  = w_la[35] & ~r_start_q;
  assign w_ack_edge    = w_la[36] & ~r_ack_q;
  assign w_clear_edge  = w_la[37] & ~r_clear_q;

  // Partial product for the current bit of B, shifted into the 64-bit accumulator space.
  assign w_term = r_b[r_cnt] ? ({32'd0, r_a} << r_cnt) : 64'd0;

  // Events that do not apply in the current state are dropped before the priority chain,
  // so an ignored higher-priority edge never masks a meaningful lower-priority one.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_next_state = r_state;
    w_load_a     = 1'b0;
    w_load_b     = 1'b0;
    w_clear_all  = 1'b0;
    w_start_mul  = 1'b0;
    if (w_clear_edge && r_state != S_BUSY) begin
      w_next_state = S_IDLE;
      w_clear_all  = 1'b1;
    end else if (w_start_edge &&
                 (r_state == S_IDLE || r_state == S_LOAD || r_state == S_BUSY)) begin
      if (r_state == S_LOAD && r_loaded_a && r_loaded_b) begin
        w_next_state = S_BUSY;
        w_start_mul  = 1'b1;
      end else begin
        w_next_state = S_ERROR;
      end
    end else if (w_strobe_edge && r_state == S_BUSY) begin
      w_next_state = S_ERROR;
    end else if (w_strobe_edge && (r_state == S_IDLE || r_state == S_LOAD) &&
                 !w_addr[1]) begin
      w_next_state = S_LOAD;
      w_load_a     = ~w_addr[0];
      w_load_b     = w_addr[0];
    end else if (w_ack_edge && r_state == S_RESULT) begin
      w_next_state = (w_data == r_acc[31:0]) ? S_DONE : S_ERROR;
    end else if (r_state == S_BUSY && r_cnt == 5'd31) begin
      w_next_state = S_RESULT;
    end
  end

  assign w_busy_step = (r_state == S_BUSY) && (w_next_state != S_ERROR);

  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (wb_rst_i) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_loaded_a <= 1'b0;
      r_loaded_b <= 1'b0;
      r_strobe_q <= 1'b0;
      r_start_q  <= 1'b0;
      r_ack_q    <= 1'b0;
      r_clear_q  <= 1'b0;
    end else begin
      r_strobe_q <= w_la[34];
      r_start_q  <= w_la[35];
      r_ack_q    <= w_la[36];
      r_clear_q  <= w_la[37];
      r_state    <= w_next_state;
      if (w_clear_all) begin
        r_a        <= '0;
        r_b        <= '0;
        r_acc      <= '0;
        r_cnt      <= '0;
        r_loaded_a <= 1'b0;
        r_loaded_b <= 1'b0;
      end else begin
        if (w_load_a) begin
          r_a        <= w_data;
          r_loaded_a <= 1'b1;
        end
        if (w_load_b) begin
          r_b        <= w_data;
          r_loaded_b <= 1'b1;
        end
        if (w_start_mul) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else if (w_busy_step) begin
          r_acc <= r_acc ^ w_term;
          r_cnt <= r_cnt + 5'd1;
        end
      end
    end
  end

  always_comb begin
    w_status = 16'hAB40;
    case (r_state)
      S_IDLE:   w_status = 16'hAB40;
      S_LOAD:   w_status = 16'hAB41;
      S_BUSY:   w_status = 16'hAB42;
      S_RESULT: w_status = 16'hAB51;
      S_DONE:   w_status = 16'hAB43;
      S_ERROR:  w_status = 16'hAB44;
      default:  w_status = 16'hAB40;
    endcase
  end

  assign w_busy         = (r_state == S_BUSY);
  assign w_result_valid = (r_state == S_RESULT) || (r_state == S_DONE);

  assign la_data_out = {59'd0, w_result_valid, w_busy, r_state,
                        (w_result_valid ? r_acc : 64'd0)};
  assign io_out      = {6'd0, w_status, 16'd0};
  assign io_oeb      = {6'h3F, 16'h0000, 16'hFFFF};

endmodule

// File: tb/tb_caravel_la_core.sv
// Directed self-checking bench for caravel_la_core: load/start/ack/clear sequences with
// hand-computed carry-less products and status words.
module tb_caravel_la_core;

  logic         wb_clk_i;
  logic         wb_rst_i;
  logic [127:0] la_data_in;
  logic [127:0] la_oenb;
  logic [127:0] la_data_out;
  logic [37:0]  io_out;
  logic [37:0]  io_oeb;

  int errors;
  int checks;

  caravel_la_core dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .la_data_in  (la_data_in),
    .la_oenb     (la_oenb),
    .la_data_out (la_data_out),
    .io_out      (io_out),
    .io_oeb      (io_oeb)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  function automatic logic [15:0] status();
    return io_out[31:16];
  endfunction

  task automatic pulse(input int idx);
    la_data_in[idx] = 1'b1;
    tick();
    la_data_in[idx] = 1'b0;
    tick();
  endtask

  task automatic load(input logic [1:0] addr, input logic [31:0] d);
    la_data_in[31:0]  = d;
    la_data_in[33:32] = addr;
    pulse(34);
  endtask

  task automatic ack(input logic [31:0] d);
    la_data_in[31:0] = d;
    pulse(36);
  endtask

  // Start, then count cycles spent in BUSY (bounded); optionally pulse clear at cycle clear_at.
  task automatic run_mul(input int clear_at, output int n);
    la_data_in[35] = 1'b1;
    tick();
    la_data_in[35] = 1'b0;
    n = 0;
    while (status() == 16'hAB42 && n < 100) begin
      n++;
      la_data_in[37] = (n == clear_at);
      tick();
    end
    la_data_in[37] = 1'b0;
  endtask

  initial begin
    int n;
    errors     = 0;
    checks     = 0;
    wb_rst_i   = 1'b1;
    la_data_in = '0;
    la_oenb    = '0;
    la_oenb[127:38] = '1;
    tick();
    tick();
    wb_rst_i = 1'b0;

    check("rst_status", status(), 16'hAB40);
    check("rst_la_out_lo", la_data_out[63:0], 64'd0);
    check("rst_la_out_hi", la_data_out[127:64], 64'd0);
    check("rst_io_oeb", io_oeb, 38'h3F_0000_FFFF);
    check("rst_io_other", {io_out[37:32], io_out[15:0]}, 22'd0);

    // Address 2 is not an operand slot; ack in IDLE is meaningless.
    load(2'd2, 32'hDEAD_BEEF);
    check("addr2_ignored", status(), 16'hAB40);
    ack(32'h0);
    check("ack_idle_ignored", status(), 16'hAB40);

    // 3 clmul 3 = 5; a clear mid-BUSY must not disturb the run.
    load(2'd0, 32'h0000_0003);
    check("load_a", status(), 16'hAB41);
    load(2'd1, 32'h0000_0003);
    check("load_b", status(), 16'hAB41);
    ack(32'h0);
    check("ack_load_ignored", status(), 16'hAB41);
    run_mul(5, n);
    check("busy_len_3x3", n, 32);
    check("result_status", status(), 16'hAB51);
    check("result_3x3", la_data_out[63:0], 64'h5);
    check("result_flags", la_data_out[68:64], {1'b1, 1'b0, 3'd3});
    ack(32'h0000_0005);
    check("ack_ok_status", status(), 16'hAB43);
    check("done_result_held", la_data_out[63:0], 64'h5);
    check("done_flags", la_data_out[68:64], {1'b1, 1'b0, 3'd4});
    pulse(37);
    check("clear_status", status(), 16'hAB40);
    check("clear_la_out", la_data_out, 128'd0);

    // All-ones operands give alternating bits; a wrong ack drops to ERROR.
    load(2'd0, 32'hFFFF_FFFF);
    load(2'd1, 32'hFFFF_FFFF);
    run_mul(0, n);
    check("busy_len_ff", n, 32);
    check("result_ff", la_data_out[63:0], 64'h5555_5555_5555_5555);
    ack(32'h0000_0000);
    check("ack_bad_status", status(), 16'hAB44);
    check("ack_bad_valid", la_data_out[68], 1'b0);
    check("ack_bad_la_out", la_data_out[63:0], 64'd0);
    pulse(37);

    // Start with only A loaded.
    load(2'd0, 32'h1234_5678);
    la_data_in[35] = 1'b1;
    tick();
    la_data_in[35] = 1'b0;
    check("start_missing_b", status(), 16'hAB44);
    pulse(37);
    check("clear_after_err", status(), 16'hAB40);
    check("clear_after_err_out", la_data_out, 128'd0);

    // Strobe during BUSY aborts.
    load(2'd0, 32'h0000_0003);
    load(2'd1, 32'h0000_0003);
    la_data_in[35] = 1'b1;
    tick();
    la_data_in[35] = 1'b0;
    check("busy_entered", la_data_out[67:64], {1'b1, 3'd2});
    for (int i = 0; i < 9; i++) tick();
    la_data_in[34] = 1'b1;
    tick();
    la_data_in[34] = 1'b0;
    check("strobe_in_busy", status(), 16'hAB44);
    pulse(37);
    check("clear_after_abort", status(), 16'hAB40);

    // Reset mid-BUSY, then a fresh run using the upper half of the product.
    load(2'd0, 32'h1234_5678);
    load(2'd1, 32'h8000_0001);
    la_data_in[35] = 1'b1;
    tick();
    la_data_in[35] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    check("rst_busy_status", status(), 16'hAB40);
    check("rst_busy_la_out", la_data_out, 128'd0);
    load(2'd0, 32'h1234_5678);
    load(2'd1, 32'h8000_0001);
    run_mul(0, n);
    check("busy_len_fresh", n, 32);
    check("result_fresh", la_data_out[63:0], 64'h091A_2B3C_1234_5678);
    check("result_fresh_status", status(), 16'hAB51);
    pulse(37);

    // A masked start bit must read as 0.
    load(2'd0, 32'h0000_0007);
    load(2'd1, 32'h0000_0002);
    la_oenb[35] = 1'b1;
    pulse(35);
    check("masked_start", status(), 16'hAB41);
    la_oenb[35] = 1'b0;
    la_data_in[35] = 1'b1;
    tick();
    la_data_in[35] = 1'b0;
    check("unmasked_start", status(), 16'hAB42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
